// File: rtl/unet_axi_pkg.sv
// AXI4 read constants, reader FSM state encoding and the burst-sizing helper
// shared by the burst reader and its testbench.
package unet_axi_pkg;

   localparam logic [2:0] SIZE_4B       = 3'b010;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;
   localparam logic [1:0] RESP_OKAY     = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Beats for the next burst: min(remaining, max_b, words left in the 4 KB page).
   function automatic logic [8:0] calc_beats(input logic [15:0]   remain,
                                             input logic [31:0]   addr,
                                             input int unsigned   max_b);
      logic [10:0] to_4k;
      logic [15:0] max_w;
      logic [15:0] b;
      to_4k = 11'd1024 - {1'b0, addr[11:2]};
      max_w = max_b[15:0];
      b     = remain;
      if (b > max_w)           b = max_w;
      if (b > {5'd0, to_4k})   b = {5'd0, to_4k};
      return b[8:0];
   endfunction

endpackage

// File: rtl/unet_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the head word, valid
// whenever empty is low.
module unet_sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_ok, rd_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates visibility of every entry.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/unet_burst_reader.sv
// AXI4 read master: splits a word-count command into 4 KB-safe INCR bursts and
// streams the words out. Define UNET_RD_RESP_CHECK_EN to flag bad rresp/rid in err.
module unet_burst_reader
   import unet_axi_pkg::*;
#(
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter logic [11:0] AXI_ID     = 12'h000
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [15:0] cmd_len,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [11:0] arid,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic [11:0] rid,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] remain_q, remain_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q, arlen_d;
   logic        arvalid_q, arvalid_d;
   logic [8:0]  beats_q, beats_d;
   logic [8:0]  beat_cnt_q, beat_cnt_d;
   logic        err_q, err_d;
   logic        done_q, done_d;

   logic        fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [AW:0] fifo_count;
   logic [32:0] fifo_wdata, fifo_rdata;
   logic [8:0]  beats_c;
   logic [15:0] free_c;
   logic        last_beat_c;
   logic        unused_ok;

   assign beats_c     = calc_beats(remain_q, addr_q, MAX_BURST);
   assign free_c      = 16'(FIFO_DEPTH) - 16'(fifo_count);
   assign last_beat_c = (beat_cnt_q == beats_q - 9'd1);

   // Top bit of each buffered word marks the final word of the command.
   assign fifo_wr    = rvalid && (state_q == ST_DATA);
   assign fifo_wdata = {last_beat_c && (remain_q == '0), rdata};
   assign fifo_rd    = out_valid && out_ready;

   unet_sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arvalid_d  = arvalid_q;
      beats_d    = beats_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_valid) begin
            err_d    = 1'b0;
            addr_d   = cmd_addr;
            remain_d = cmd_len;
            if (cmd_len == '0) done_d  = 1'b1;
            else               state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (arvalid_q) begin
               if (arready) begin
                  arvalid_d  = 1'b0;
                  addr_d     = addr_q + {21'd0, beats_q, 2'b00};
                  remain_d   = remain_q - {7'd0, beats_q};
                  beat_cnt_d = '0;
                  state_d    = ST_DATA;
               end
            end else if ({7'd0, beats_c} <= free_c) begin
               // Only issue once the whole burst is guaranteed a FIFO slot.
               arvalid_d = 1'b1;
               araddr_d  = addr_q;
               arlen_d   = 8'(beats_c - 9'd1);
               beats_d   = beats_c;
            end
         end
         ST_DATA: if (rvalid) begin
            beat_cnt_d = beat_cnt_q + 9'd1;
            if (rlast != last_beat_c) err_d = 1'b1;
`ifdef UNET_RD_RESP_CHECK_EN
            if ((rresp != RESP_OKAY) || (rid != AXI_ID)) err_d = 1'b1;
`endif
            if (last_beat_c) state_d = (remain_q != '0) ? ST_ADDR : ST_DRAIN;
         end
         ST_DRAIN: if (fifo_empty) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arvalid_q  <= 1'b0;
         beats_q    <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arvalid_q  <= arvalid_d;
         beats_q    <= beats_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

`ifdef UNET_RD_RESP_CHECK_EN
   assign unused_ok = fifo_full;
`else
   assign unused_ok = ^{fifo_full, rresp, rid};
`endif

   assign cmd_ready = (state_q == ST_IDLE);
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = SIZE_4B;
   assign arburst   = BURST_INCR;
   assign arid      = AXI_ID;
   assign arcache   = CACHE_DEFAULT;
   assign arprot    = PROT_DEFAULT;
   assign arvalid   = arvalid_q;
   assign rready    = (state_q == ST_DATA);
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rdata[31:0];
   assign out_last  = fifo_rdata[32] && !fifo_empty;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_unet_burst_reader.sv
// Scoreboard bench for unet_burst_reader: directed commands, an AXI slave
// model, and a negedge monitor checking AR requests and the output stream.
module tb_unet_burst_reader;

   logic        ACLK = 1'b0;
   logic        ARESET, cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, rresp;
   logic [11:0] arid, rid;
   logic [3:0]  arcache;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [31:0] rdata, out_data;
   logic        out_valid, out_ready, out_last, busy, done, err;

`ifdef UNET_RD_RESP_CHECK_EN
   localparam logic RESP_ERR_EXP = 1'b1;
`else
   localparam logic RESP_ERR_EXP = 1'b0;
`endif

   typedef struct { logic [31:0] a; logic [7:0] l; } ar_t;
   typedef struct { logic [31:0] d; logic last; } ow_t;
   ar_t exp_ar[$];
   ow_t exp_out[$];
   logic [31:0] bq_a[$];
   logic [7:0]  bq_l[$];

   int n_cmp = 0, n_err = 0, ar_cnt = 0, cmd_beat = 0;
   int inj_resp_beat = 0, inj_nolast_beat = 0;

   unet_burst_reader dut (
      .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arid(arid), .arcache(arcache),
      .arprot(arprot), .arvalid(arvalid), .arready(arready), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done), .err(err)
   );

   always #5 ACLK = ~ACLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[31:16]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
      exp_ar.push_back('{a: a, l: l});
   endtask

   task automatic push_words(input logic [31:0] a, input int len);
      for (int i = 0; i < len; i++)
         exp_out.push_back('{d: mem_word(a + 32'(i * 4)), last: (i == len - 1)});
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [15:0] len);
      logic got;
      got = 1'b0;
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; cmd_beat = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge ACLK);
         if (cmd_ready) begin got = 1'b1; break; end
      end
      check("cmd_accept", 32'(got), 32'd1);
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge ACLK);
         if (done) begin got = 1'b1; break; end
      end
      check(name, 32'(got), 32'd1);
      if (got) begin
         check("busy_at_done", 32'(busy), 32'd0);
         @(negedge ACLK);
         check("done_one_pulse", 32'(done), 32'd0);
      end
      check("ar_queue_drained", 32'(exp_ar.size()), 32'd0);
      check("out_queue_drained", 32'(exp_out.size()), 32'd0);
   endtask

   // AXI slave: capture AR, return one burst at a time with back-to-back beats.
   initial begin
      logic ar_f, r_f, rst_s;
      logic [31:0] a_s;
      logic [7:0]  l_s;
      int beat;
      beat = 0;
      rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00; rid = 12'h000;
      forever begin
         @(negedge ACLK);
         rst_s = ARESET;
         ar_f  = arvalid && arready && !ARESET;
         r_f   = rvalid && rready && !ARESET;
         a_s   = araddr;
         l_s   = arlen;
         @(posedge ACLK); #1;
         if (rst_s) begin
            bq_a.delete(); bq_l.delete(); beat = 0;
         end else begin
            if (r_f) begin
               cmd_beat++;
               beat++;
               if (beat > int'(bq_l[0])) begin
                  void'(bq_a.pop_front()); void'(bq_l.pop_front()); beat = 0;
               end
            end
            if (ar_f) begin bq_a.push_back(a_s); bq_l.push_back(l_s); end
         end
         if (bq_a.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(bq_a[0] + 32'(beat * 4));
            rlast  = (beat == int'(bq_l[0])) &&
                     !(inj_nolast_beat != 0 && cmd_beat + 1 == inj_nolast_beat);
            rresp  = (inj_resp_beat != 0 && cmd_beat + 1 == inj_resp_beat) ? 2'b10 : 2'b00;
         end else begin
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT completes an AR or out handshake.
   initial begin
      ar_t ea;
      ow_t eo;
      forever begin
         @(negedge ACLK);
         if (!ARESET) begin
            if (arvalid && arready) begin
               ar_cnt++;
               if (exp_ar.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL ar_unexpected: got araddr %h arlen %0d expected no request", araddr, arlen);
               end else begin
                  ea = exp_ar.pop_front();
                  check("ar_addr", araddr, ea.a);
                  check("ar_len", 32'(arlen), 32'(ea.l));
               end
            end
            if (out_valid && out_ready) begin
               if (exp_out.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL out_unexpected: got word %h expected no word", out_data);
               end else begin
                  eo = exp_out.pop_front();
                  check("out_data", out_data, eo.d);
                  check("out_last", 32'(out_last), 32'(eo.last));
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish before 400 us");
      $fatal(1, "timeout");
   end

   initial begin
      ARESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      arready = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_arlen", 32'(arlen), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("const_fields", {8'd0, arsize, arburst, arcache, arprot, arid}, {8'd0, 3'b010, 2'b01, 4'b0011, 3'b000, 12'h000});
      @(posedge ACLK); #1;
      ARESET = 1'b0;

      // 40 words: bursts of 16, 16, 8.
      push_ar(32'h4580_0000, 8'd15); push_ar(32'h4580_0040, 8'd15); push_ar(32'h4580_0080, 8'd7);
      push_words(32'h4580_0000, 40);
      send_cmd(32'h4580_0000, 16'd40);
      @(negedge ACLK);
      check("busy_running", 32'(busy), 32'd1);
      wait_done("done_len40");

      // Split at the 4 KB page boundary.
      push_ar(32'h0000_0FF0, 8'd3); push_ar(32'h0000_1000, 8'd3);
      push_words(32'h0000_0FF0, 8);
      send_cmd(32'h0000_0FF0, 16'd8);
      wait_done("done_4k");

      // Zero length: done the cycle after acceptance, no traffic.
      send_cmd(32'h0000_0100, 16'd0);
      @(negedge ACLK);
      check("len0_done", 32'(done), 32'd1);
      check("len0_out_valid", 32'(out_valid), 32'd0);
      check("len0_arvalid", 32'(arvalid), 32'd0);
      @(negedge ACLK);
      check("len0_done_pulse", 32'(done), 32'd0);

      // Output stalled: only two bursts fit the 32-word buffer.
      out_ready = 1'b0;
      ar_cnt = 0;
      for (int i = 0; i < 4; i++) push_ar(32'h1000_0000 + 32'(i * 64), 8'd15);
      push_words(32'h1000_0000, 64);
      send_cmd(32'h1000_0000, 16'd64);
      repeat (150) @(negedge ACLK);
      check("bp_ar_count", 32'(ar_cnt), 32'd2);
      check("bp_arvalid", 32'(arvalid), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge ACLK); #1;
      out_ready = 1'b1;
      wait_done("done_backpressure");

      // Error response on beat 3.
      inj_resp_beat = 3;
      push_ar(32'h0000_2000, 8'd7);
      push_words(32'h0000_2000, 8);
      send_cmd(32'h0000_2000, 16'd8);
      wait_done("done_resp_err");
      check("resp_err", 32'(err), 32'(RESP_ERR_EXP));
      repeat (5) @(negedge ACLK);
      check("resp_err_sticky", 32'(err), 32'(RESP_ERR_EXP));
      inj_resp_beat = 0;

      // Missing rlast on the end of the first burst; err clears on acceptance.
      inj_nolast_beat = 16;
      push_ar(32'h0000_3000, 8'd15); push_ar(32'h0000_3040, 8'd3);
      push_words(32'h0000_3000, 20);
      send_cmd(32'h0000_3000, 16'd20);
      @(negedge ACLK);
      check("err_clear_on_accept", 32'(err), 32'd0);
      wait_done("done_nolast");
      check("rlast_err", 32'(err), 32'd1);
      inj_nolast_beat = 0;

      // Reset in the middle of a data burst.
      push_ar(32'h0000_5000, 8'd15); push_ar(32'h0000_5040, 8'd15);
      push_words(32'h0000_5000, 32);
      send_cmd(32'h0000_5000, 16'd32);
      begin
         logic got;
         got = 1'b0;
         for (int k = 0; k < 500; k++) begin
            @(negedge ACLK);
            if (cmd_beat >= 5) begin got = 1'b1; break; end
         end
         check("mid_reach_data", 32'(got), 32'd1);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      exp_ar.delete(); exp_out.delete();
      @(negedge ACLK);
      check("mid_arvalid", 32'(arvalid), 32'd0);
      check("mid_rready", 32'(rready), 32'd0);
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_err", 32'(err), 32'd0);
      check("mid_araddr", araddr, 32'd0);
      check("mid_arlen", 32'(arlen), 32'd0);

      push_ar(32'h0000_6000, 8'd3);
      push_words(32'h0000_6000, 4);
      send_cmd(32'h0000_6000, 16'd4);
      wait_done("done_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/unet_burst_reader.md
UNET_BURST_READER -- requirements
Module: unet_burst_reader

Interface
REQ-001 Parameter MAX_BURST, default 16, max beats per AXI4 read burst (power of two, 1..256).
REQ-002 Parameter FIFO_DEPTH, default 32, read-data buffer depth in words (power of two, >= MAX_BURST).
REQ-003 Parameter AXI_ID, default 12'h000, constant ARID value.
REQ-004 ACLK  in  1  sole clock, all logic on rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-007 cmd_addr  in  32  start byte address, word aligned.
REQ-008 cmd_len  in  16  transfer length in 32-bit words.
REQ-009 M01 AR channel: araddr out 32, arlen out 8, arsize out 3, arburst out 2, arid out 12, arcache out 4, arprot out 3, arvalid out 1, arready in 1.
REQ-010 M01 R channel: rdata in 32, rresp in 2, rlast in 1, rid in 12, rvalid in 1, rready out 1.
REQ-011 out_data  out  32 / out_valid  out  1 / out_ready  in  1 / out_last  out  1: word stream to BRAM writer.
REQ-012 busy  out  1 command in progress; done  out  1 one-cycle completion pulse; err  out  1 sticky error.

Function
REQ-013 arsize SHALL be 3'b010, arburst 2'b01 (INCR), arcache 4'b0011, arprot 3'b000, arid AXI_ID at all times.
REQ-014 cmd_ready SHALL be high only in IDLE; command accepted on cmd_valid&&cmd_ready.
REQ-015 cmd_len==0 SHALL complete without AR traffic: done pulses the cycle after acceptance, no out beats.
REQ-016 FSM states IDLE, ADDR, DATA, DRAIN: IDLE->ADDR on accept (len>0); ADDR->DATA on arvalid&&arready; DATA->ADDR on last R beat if words remain, else ->DRAIN; DRAIN->IDLE when FIFO empty and final beat consumed.
REQ-017 Burst beats SHALL equal min(remaining words, MAX_BURST, words to next 4 KB boundary); arlen = beats-1.
REQ-018 arvalid SHALL assert in ADDR only when FIFO free space >= beats of that burst; once asserted, arvalid/araddr/arlen held stable until arready.
REQ-019 Exactly one burst outstanding; address advances by beats*4 after each accepted AR.
REQ-020 rready SHALL be high in DATA; FIFO space guaranteed by REQ-018 so no R beat is dropped.
REQ-021 Each R beat SHALL be written to FIFO the same cycle; out_valid reflects FIFO not-empty, first beat visible on out_data one cycle after its R handshake.
REQ-022 out_last SHALL be high with the final word of the command only.
REQ-023 Simultaneous FIFO write and read SHALL keep occupancy unchanged; full FIFO never overwritten, empty never underflows.
REQ-024 done pulses one cycle on DRAIN->IDLE; busy high in every state except IDLE.
REQ-025 rlast mismatch (rlast early or absent on final expected beat) SHALL set err; beat counting follows internal count.

Reset
REQ-026 On ARESET: state IDLE, arvalid 0, rready 0, out_valid 0, out_last 0, done 0, busy 0, err 0, araddr 0, arlen 0, FIFO empty, counters 0.
REQ-027 ARESET mid-transfer SHALL abort immediately to reset values; outstanding AXI beats are the system's responsibility.
REQ-028 err SHALL clear only on reset or on next command acceptance.

Configuration
REQ-029 Macro UNET_RD_RESP_CHECK_EN: when defined, rresp != 2'b00 or rid != AXI_ID on any beat SHALL set err; when undefined, rresp/rid ignored and err set only by REQ-025.

Structure
REQ-030 Package unet_axi_pkg SHALL hold AXI constants (SIZE_4B, BURST_INCR, CACHE_DEFAULT, RESP_OKAY) and the FSM state enum.
REQ-031 Sub-module unet_sync_fifo (parameterised width/depth, occupancy output) SHALL implement the buffer.

Verification
REQ-032 cmd addr=0x4580_0000 len=40, MAX_BURST=16, arready/out_ready always 1 -> ARs arlen 15,15,7 at 0x4580_0000/0040/0080; 40 out beats; out_last on beat 40; done one pulse.
REQ-033 cmd addr=0x0000_0FF0 len=8 -> ARs arlen 3 at 0x0FF0 then arlen 3 at 0x1000; no 4 KB crossing.
REQ-034 out_ready held 0, len=64 -> after 32 words buffered no further arvalid; release -> all 64 words delivered in order, none lost.
REQ-035 cmd len=0 -> no arvalid, done pulses next cycle, out_valid stays 0.
REQ-036 With UNET_RD_RESP_CHECK_EN, rresp=2'b10 on beat 3 -> err=1 sticky until next command; without macro err stays 0.
REQ-037 ARESET asserted during DATA of len=32 -> next cycle all outputs at reset values; new cmd len=4 completes normally.
